// File: rtl/wb_pkg.sv
// Shared widths and the queued load-result record for the register-file writeback stage.
package wb_pkg;

  localparam int unsigned XLEN               = 32;
  localparam int unsigned REG_ADDR_W         = 5;
  localparam int unsigned NUM_REGS           = 32;
  localparam int unsigned DEFAULT_FIFO_DEPTH = 4;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] sel;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Generic circular FIFO with occupancy count; pointers wrap modulo DEPTH.
module wb_fifo #(
  parameter int unsigned WIDTH = 37,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned      PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign full_o  = (r_count == FULL);
  assign empty_o = (r_count == '0);
  assign count_o = r_count;
  assign rdata_o = r_mem[r_rptr];

  // A push into a full queue is legal when the head leaves on the same edge.
  assign w_push = push_i && (!full_o || pop_i);
  assign w_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= (r_wptr == LAST) ? '0 : r_wptr + 1'b1;
      if (w_pop)  r_rptr <= (r_rptr == LAST) ? '0 : r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= wdata_i;
  end

endmodule

// File: rtl/regfile_writeback.sv
// Writeback arbiter: ALU results beat queued load results to the single register-file write
// port; also keeps the pending-register scoreboard and a one-entry forwarding tap.
module regfile_writeback
  import wb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  alu_valid_i,
  input  logic [REG_ADDR_W-1:0] alu_sel_i,
  input  logic [XLEN-1:0]       alu_data_i,
  input  logic                  lsu_valid_i,
  input  logic [REG_ADDR_W-1:0] lsu_sel_i,
  input  logic [XLEN-1:0]       lsu_data_i,
  output logic                  lsu_ready_o,
  input  logic                  reserve_i,
  input  logic [REG_ADDR_W-1:0] reserveSel_i,
  output logic [REG_ADDR_W-1:0] selRd_o,
  output logic [XLEN-1:0]       rd_o,
  output logic [NUM_REGS-1:0]   busy_o,
  input  logic [REG_ADDR_W-1:0] fwdSel_i,
  output logic                  fwdHit_o,
  output logic [XLEN-1:0]       fwdData_o,
  output logic [2:0]            fifoCount_o
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  wb_entry_t             w_head;
  wb_entry_t             w_push_entry;
  logic                  w_alu_win;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_empty;
  logic                  w_full;
  logic [CNT_W-1:0]      w_count;
  logic [REG_ADDR_W-1:0] w_sel_d;
  logic [XLEN-1:0]       w_rd_d;
  logic [NUM_REGS-1:0]   w_busy_d;
  logic [REG_ADDR_W-1:0] r_sel;
  logic [XLEN-1:0]       r_rd;
  logic [NUM_REGS-1:0]   r_busy;

  assign lsu_ready_o  = !w_full;
  // Loads to x0 complete the handshake but never occupy a slot.
  assign w_push       = lsu_valid_i && lsu_ready_o && (lsu_sel_i != '0);
  assign w_alu_win    = alu_valid_i && (alu_sel_i != '0);
  assign w_pop        = !w_alu_win && !w_empty;
  assign w_push_entry = '{sel: lsu_sel_i, data: lsu_data_i};

  wb_fifo #(
    .WIDTH($bits(wb_entry_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (w_push),
    .pop_i  (w_pop),
    .wdata_i(w_push_entry),
    .rdata_o(w_head),
    .count_o(w_count),
    .full_o (w_full),
    .empty_o(w_empty)
  );

  always_comb begin
    w_sel_d = '0;
    w_rd_d  = r_rd;
    if (w_alu_win) begin
      w_sel_d = alu_sel_i;
      w_rd_d  = alu_data_i;
    end else if (w_pop) begin
      w_sel_d = w_head.sel;
      w_rd_d  = w_head.data;
    end
  end

  // Clear follows the driven write; a same-edge reservation of that register wins.
  always_comb begin
    w_busy_d        = r_busy;
    w_busy_d[r_sel] = 1'b0;
    if (reserve_i) w_busy_d[reserveSel_i] = 1'b1;
    w_busy_d[0]     = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_sel  <= '0;
      r_rd   <= '0;
      r_busy <= '0;
    end else begin
      r_sel  <= w_sel_d;
      r_rd   <= w_rd_d;
      r_busy <= w_busy_d;
    end
  end

  assign selRd_o     = r_sel;
  assign rd_o        = r_rd;
  assign busy_o      = r_busy;
  assign fifoCount_o = 3'(w_count);
  assign fwdHit_o    = (fwdSel_i != '0) && (fwdSel_i == r_sel);
  assign fwdData_o   = fwdHit_o ? r_rd : '0;

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: vector table, directed multi-cycle scenarios, then random
// traffic against a queue-based reference model.
module tb_regfile_writeback;

  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        alu_valid_i = 1'b0;
  logic [4:0]  alu_sel_i = '0;
  logic [31:0] alu_data_i = '0;
  logic        lsu_valid_i = 1'b0;
  logic [4:0]  lsu_sel_i = '0;
  logic [31:0] lsu_data_i = '0;
  logic        lsu_ready_o;
  logic        reserve_i = 1'b0;
  logic [4:0]  reserveSel_i = '0;
  logic [4:0]  selRd_o;
  logic [31:0] rd_o;
  logic [31:0] busy_o;
  logic [4:0]  fwdSel_i = '0;
  logic        fwdHit_o;
  logic [31:0] fwdData_o;
  logic [2:0]  fifoCount_o;

  regfile_writeback #(.FIFO_DEPTH(DEPTH)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .alu_valid_i (alu_valid_i),
    .alu_sel_i   (alu_sel_i),
    .alu_data_i  (alu_data_i),
    .lsu_valid_i (lsu_valid_i),
    .lsu_sel_i   (lsu_sel_i),
    .lsu_data_i  (lsu_data_i),
    .lsu_ready_o (lsu_ready_o),
    .reserve_i   (reserve_i),
    .reserveSel_i(reserveSel_i),
    .selRd_o     (selRd_o),
    .rd_o        (rd_o),
    .busy_o      (busy_o),
    .fwdSel_i    (fwdSel_i),
    .fwdHit_o    (fwdHit_o),
    .fwdData_o   (fwdData_o),
    .fifoCount_o (fifoCount_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  // Reference model: pending loads, last write, pending-register set.
  logic [36:0] mq[$];
  logic [4:0]  m_sel;
  logic [31:0] m_rd;
  logic [31:0] m_busy;

  typedef struct {
    logic        av;
    logic [4:0]  as;
    logic [31:0] ad;
    logic        lv;
    logic [4:0]  ls;
    logic [31:0] ld;
    logic [4:0]  esel;
    logic [31:0] erd;
    logic [2:0]  ecnt;
  } vec_t;

  vec_t vt[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] as, input logic [31:0] ad,
                       input logic lv, input logic [4:0] ls, input logic [31:0] ld,
                       input logic rv, input logic [4:0] rs);
    alu_valid_i  = av;
    alu_sel_i    = as;
    alu_data_i   = ad;
    lsu_valid_i  = lv;
    lsu_sel_i    = ls;
    lsu_data_i   = ld;
    reserve_i    = rv;
    reserveSel_i = rs;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic model_step();
    logic [36:0] e;
    logic [4:0]  nsel;
    logic [31:0] nrd;
    logic        rdy;
    rdy = (mq.size() < DEPTH);
    if (alu_valid_i && alu_sel_i != 5'd0) begin
      nsel = alu_sel_i;
      nrd  = alu_data_i;
    end else if (mq.size() > 0) begin
      e    = mq.pop_front();
      nsel = e[36:32];
      nrd  = e[31:0];
    end else begin
      nsel = 5'd0;
      nrd  = m_rd;
    end
    if (lsu_valid_i && rdy && lsu_sel_i != 5'd0) mq.push_back({lsu_sel_i, lsu_data_i});
    if (m_sel != 5'd0) m_busy[m_sel] = 1'b0;
    if (reserve_i) m_busy[reserveSel_i] = 1'b1;
    m_busy[0] = 1'b0;
    m_sel     = nsel;
    m_rd      = nrd;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic hs;
    int   k;

    // Reset values while held in reset.
    #2;
    check("rst sel", 32'(selRd_o), 32'd0);
    check("rst rd", rd_o, 32'd0);
    check("rst busy", busy_o, 32'd0);
    check("rst cnt", 32'(fifoCount_o), 32'd0);
    check("rst ready", 32'(lsu_ready_o), 32'd1);
    @(negedge clk_i);
    rst_i = 1'b1;

    //          av  as  ad        lv  ls  ld       esel erd     ecnt
    vt[0] = '{1'b1, 5'd3, 32'hA,    1'b1, 5'd7, 32'hB,  5'd7 - 5'd4, 32'hA,  3'd1};
    vt[1] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,  5'd7, 32'hB,  3'd0};
    vt[2] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,  5'd0, 32'hB,  3'd0};
    vt[3] = '{1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'h0,  5'd0, 32'hB,  3'd0};
    vt[4] = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd0, 32'h77, 5'd0, 32'hB,  3'd0};
    vt[5] = '{1'b1, 5'd9, 32'h55,   1'b0, 5'd0, 32'h0,  5'd9, 32'h55, 3'd0};
    vt[6] = '{1'b1, 5'd0, 32'h1,    1'b1, 5'd4, 32'h44, 5'd0, 32'h55, 3'd1};
    vt[7] = '{1'b1, 5'd0, 32'h2,    1'b0, 5'd0, 32'h0,  5'd4, 32'h44, 3'd0};
    vt[8] = '{1'b1, 5'd2, 32'h22,   1'b1, 5'd2, 32'h33, 5'd2, 32'h22, 3'd1};
    vt[9] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,  5'd2, 32'h33, 3'd0};

    for (int i = 0; i < 10; i++) begin
      drive(vt[i].av, vt[i].as, vt[i].ad, vt[i].lv, vt[i].ls, vt[i].ld, 1'b0, 5'd0);
      tick();
      check($sformatf("vec%0d sel", i), 32'(selRd_o), 32'(vt[i].esel));
      check($sformatf("vec%0d rd", i), rd_o, vt[i].erd);
      check($sformatf("vec%0d cnt", i), 32'(fifoCount_o), 32'(vt[i].ecnt));
      fwdSel_i = vt[i].esel;
      #1;
      check($sformatf("vec%0d fwdhit", i), 32'(fwdHit_o), 32'(vt[i].esel != 5'd0));
      check($sformatf("vec%0d fwddata", i), fwdData_o,
            (vt[i].esel != 5'd0) ? vt[i].erd : 32'd0);
    end
    fwdSel_i = 5'd0;

    // Reserve then commit x5; busy clears one edge after the write is driven.
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5);
    tick();
    check("rsv busy set", busy_o, 32'h20);
    drive(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    tick();
    check("rsv sel", 32'(selRd_o), 32'd5);
    check("rsv rd", rd_o, 32'h1234);
    check("rsv busy held", busy_o, 32'h20);
    idle();
    tick();
    check("rsv busy clr", busy_o, 32'h0);

    // Queue full while ALU owns the port, then in-order drain.
    k = 0;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("full ready%0d", i), 32'(lsu_ready_o), 32'(i < DEPTH));
      drive(1'b1, 5'd1, 32'(i), (k < 5), 5'(10 + k), 32'(256 + k), 1'b0, 5'd0);
      hs = lsu_ready_o && lsu_valid_i;
      tick();
      if (hs) k++;
    end
    check("full cnt", 32'(fifoCount_o), 32'd4);
    idle();
    for (int j = 0; j < 4; j++) begin
      tick();
      check($sformatf("drain sel%0d", j), 32'(selRd_o), 32'(10 + j));
      check($sformatf("drain rd%0d", j), rd_o, 32'(256 + j));
    end
    check("drain cnt", 32'(fifoCount_o), 32'd0);

    // Mid-operation reset with queued loads and pending reservations.
    drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd20, 32'h200, 1'b1, 5'd8);
    tick();
    drive(1'b1, 5'd1, 32'h2, 1'b1, 5'd21, 32'h201, 1'b1, 5'd9);
    tick();
    drive(1'b1, 5'd1, 32'h3, 1'b1, 5'd22, 32'h202, 1'b0, 5'd0);
    tick();
    check("mid cnt", 32'(fifoCount_o), 32'd3);
    check("mid busy", busy_o, 32'h300);
    idle();
    #2;
    rst_i = 1'b0;
    #1;
    check("mid rst sel", 32'(selRd_o), 32'd0);
    check("mid rst rd", rd_o, 32'd0);
    check("mid rst busy", busy_o, 32'd0);
    check("mid rst cnt", 32'(fifoCount_o), 32'd0);
    check("mid rst ready", 32'(lsu_ready_o), 32'd1);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    tick();
    check("post rst sel", 32'(selRd_o), 32'd0);
    check("post rst cnt", 32'(fifoCount_o), 32'd0);

    // Random traffic against the reference model.
    mq.delete();
    m_sel  = 5'd0;
    m_rd   = 32'd0;
    m_busy = 32'd0;
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom,
            $urandom_range(0, 9) < 7, 5'($urandom_range(0, 31)), $urandom,
            $urandom_range(0, 3) == 0, 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 9) < 4) alu_sel_i = 5'd0;
      fwdSel_i = ($urandom_range(0, 1) == 1) ? m_sel : 5'($urandom_range(0, 31));
      #1;
      check("rnd ready", 32'(lsu_ready_o), 32'(mq.size() < DEPTH));
      check("rnd fwdhit", 32'(fwdHit_o), 32'(fwdSel_i != 5'd0 && fwdSel_i == m_sel));
      check("rnd fwddata", fwdData_o, (fwdSel_i != 5'd0 && fwdSel_i == m_sel) ? m_rd : 32'd0);
      model_step();
      tick();
      check("rnd sel", 32'(selRd_o), 32'(m_sel));
      check("rnd rd", rd_o, m_rd);
      check("rnd busy", busy_o, m_busy);
      check("rnd cnt", 32'(fifoCount_o), 32'(mq.size()));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_writeback.md
REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

Interface
REQ-001 The block SHALL have one clock, clk_i; reset is asynchronous and active-low, named rst_i.
REQ-002 Parameter FIFO_DEPTH, default 4: number of entries in the load-result queue.
REQ-003 Port clk_i  input  1  rising-edge clock.
REQ-004 Port rst_i  input  1  asynchronous reset, active-low.
REQ-005 Port alu_valid_i  input  1  ALU result present this cycle; always accepted, no backpressure.
REQ-006 Port alu_sel_i  input  5  ALU destination register index.
REQ-007 Port alu_data_i  input  32  ALU result value.
REQ-008 Port lsu_valid_i  input  1  load result offered.
REQ-009 Port lsu_sel_i  input  5  load destination register index.
REQ-010 Port lsu_data_i  input  32  load result value.
REQ-011 Port lsu_ready_o  output  1  queue can accept a load result.
REQ-012 Port reserve_i  input  1  decode marks a destination register pending.
REQ-013 Port reserveSel_i  input  5  register index to reserve.
REQ-014 Port selRd_o  output  5  register-file write select; 0 means no write.
REQ-015 Port rd_o  output  32  register-file write data.
REQ-016 Port busy_o  output  32  scoreboard, one pending bit per register.
REQ-017 Port fwdSel_i  input  5  forwarding lookup index.
REQ-018 Port fwdHit_o  output  1  fwdSel_i matches the write currently driven.
REQ-019 Port fwdData_o  output  32  forwarded value; 0 when fwdHit_o is 0.
REQ-020 Port fifoCount_o  output  3  current queue occupancy.

Function
REQ-021 The block SHALL drive selRd_o and rd_o only from registers, giving a 1-cycle latency from acceptance to the write port.
REQ-022 A load transfer SHALL occur on a rising edge when lsu_valid_i and lsu_ready_o are both 1; the transfer pushes the load result into the queue.
REQ-023 lsu_ready_o SHALL be 1 exactly when fifoCount_o < FIFO_DEPTH, and SHALL not depend on lsu_valid_i.
REQ-024 Each cycle, the write-port arbiter SHALL select, in priority order: (1) an ALU result with alu_sel_i != 0; (2) the queue head, if the queue is non-empty; (3) no write, with selRd_o = 0 and rd_o holding its value.
REQ-025 The queue SHALL pop only when its head is selected for the write port.
REQ-026 A push and a pop in the same cycle SHALL leave fifoCount_o unchanged; this also applies when the queue is full.
REQ-027 The queue SHALL be first-in, first-out, with read and write pointers that wrap modulo FIFO_DEPTH.
REQ-028 A load result with lsu_sel_i == 0 SHALL be handshaken but not enqueued.
REQ-029 An ALU result with alu_sel_i == 0 SHALL be dropped and SHALL not block the queue.
REQ-030 busy_o[n] SHALL be set on an edge with reserve_i=1 and reserveSel_i=n.
REQ-031 busy_o[n] SHALL be cleared on the edge after selRd_o==n has been driven.
REQ-032 If a set and a clear of the same bit occur on the same edge, the set SHALL win.
REQ-033 busy_o[0] SHALL be constant 0.
REQ-034 fwdHit_o SHALL be combinational, equal to (fwdSel_i != 0) && (fwdSel_i == selRd_o).
REQ-035 When fwdHit_o is 1, fwdData_o SHALL equal rd_o.
REQ-036 If an ALU result and a load result target the same register in the same cycle, the ALU write SHALL occur first and the load write later, so the load value prevails.

Reset
REQ-037 While rst_i is 0, the block SHALL hold selRd_o=0, rd_o=0, busy_o=0, fifoCount_o=0 and empty queue pointers, and lsu_ready_o SHALL be 1.
REQ-038 Reset asserted mid-operation SHALL immediately discard all queued results and all pending reservations.
REQ-039 No register-file write SHALL be emitted in the first cycle after reset is deasserted.

Structure
REQ-040 Package wb_pkg SHALL hold XLEN=32, REG_ADDR_W=5, NUM_REGS=32 and the default FIFO_DEPTH.
REQ-041 The queue SHALL be implemented as sub-module wb_fifo, with push/pop/data/count ports and no knowledge of register semantics.
REQ-042 The arbiter, scoreboard and forwarding logic SHALL reside in regfile_writeback.

Verification
REQ-043 Scenario reserve/commit: reserve x5, then ALU x5=0x1234 -> next cycle selRd_o=5 and rd_o=0x1234; busy_o[5] is cleared one edge later.
REQ-044 Scenario ALU priority: ALU x3=0xA and load x7=0xB in the same cycle -> write x3 first, then x7; fifoCount_o reads 1 then 0.
REQ-045 Scenario queue full: hold ALU valid to x1 for 6 cycles while pushing 5 loads -> lsu_ready_o=0 after 4 loads; the loads drain in order x10..x13 once the ALU stops.
REQ-046 Scenario x0 and forwarding: ALU x0=0xFFFF -> selRd_o stays 0; ALU x9=0x55 with fwdSel_i=9 -> fwdHit_o=1 and fwdData_o=0x55 in the write cycle.
REQ-047 Scenario mid-reset: pull rst_i low with 3 queued loads and busy_o=0x0000_0300 -> all outputs return to their reset values asynchronously, and no write follows release.
